csa_accum_ctrl: RTL and testbench

Sequencing controller that accumulates a stream of unsigned operands through a single carry-save adder, keeping the running total in redundant (sum, carry) form, then resolves it to binary by iterating the same adder. It sits between an operand producer and a result consumer, with a valid/ready handshake on each side. It is the block that owns and time-shares the CSA datapath; no carry-propagate adder is instantiated.

---
 rtl/csa_pkg.sv | 29 ++
 rtl/csa_n.sv | 16 +
 rtl/csa_accum_ctrl.sv | 117 +++++++++++
 tb/tb_csa_accum_ctrl.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/csa_pkg.sv
// Shared types, default sizes and helpers for the carry-save accumulator controller.
package csa_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ACCUM   = 2'd1,
      RESOLVE = 2'd2,
      DONE    = 2'd3
   } state_t;

   localparam int DEF_WIDTH = 4;
   localparam int DEF_ACC_W = 8;
   localparam int DEF_CNT_W = 8;

   // Widest operand the zext helper can carry; callers cast down to their own width.
   localparam int ZEXT_MAX = 64;

   function automatic logic [ZEXT_MAX-1:0] zext(input logic [ZEXT_MAX-1:0] v,
                                                input int unsigned w);
      logic [ZEXT_MAX-1:0] mask;
      if (w >= ZEXT_MAX) begin
         mask = '1;
      end else begin
         mask = (ZEXT_MAX'(1) << w) - ZEXT_MAX'(1);
      end
      return v & mask;
   endfunction

endpackage

// File: rtl/csa_n.sv
// N-bit carry-save adder: three operands in, bitwise sum and majority carry out.
// Purely combinational; the caller applies the carry shift.
module csa_n #(
   parameter int N = 4
) (
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  logic [N-1:0] c,
   output logic [N-1:0] s,
   output logic [N-1:0] co
);

   assign s  = a ^ b ^ c;
   assign co = (a & b) | (b & c) | (a & c);

endmodule

// File: rtl/csa_accum_ctrl.sv
// Accumulates operands in redundant (S, C) form through one CSA, then resolves by iterating it.
// Result valid k+1 cycles after the last operand (k <= ACC_W); holds the result until out_ready.
module csa_accum_ctrl
   import csa_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int ACC_W = DEF_ACC_W,
   parameter int CNT_W = DEF_CNT_W
) (
   input  logic             CLK,
   input  logic             ASYNCRESETN,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_last,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [ACC_W-1:0] out_sum,
   output logic [CNT_W-1:0] out_count
);

   state_t state_q;
   state_t state_d;

   logic [ACC_W-1:0] s_q;
   logic [ACC_W-1:0] s_d;
   logic [ACC_W-1:0] c_q;
   logic [ACC_W-1:0] c_d;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   logic [ACC_W-1:0] x;
   logic [ACC_W-1:0] csa_c;
   logic [ACC_W-1:0] csa_s;
   logic [ACC_W-1:0] csa_co;
   logic [ACC_W-1:0] co_sh;
   logic [CNT_W-1:0] cnt_inc;
   logic             resolving;

   assign x = ACC_W'(zext(ZEXT_MAX'(in_data), WIDTH));

   // During RESOLVE the third operand is zero, so the same adder computes S^C and S&C.
   assign resolving = (state_q == RESOLVE);
   assign csa_c     = resolving ? '0 : x;

   csa_n #(
      .N (ACC_W)
   ) u_csa (
      .a  (s_q),
      .b  (c_q),
      .c  (csa_c),
      .s  (csa_s),
      .co (csa_co)
   );

   assign co_sh   = csa_co << 1;
   assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + 1'b1;

   always_ff @(posedge CLK or negedge ASYNCRESETN) begin
      if (!ASYNCRESETN) begin
         state_q <= IDLE;
         s_q     <= '0;
         c_q     <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         s_q     <= s_d;
         c_q     <= c_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      s_d       = s_q;
      c_d       = c_q;
      cnt_d     = cnt_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;

      case (state_q)
         IDLE, ACCUM: begin
            in_ready = 1'b1;
            if (in_valid) begin
               s_d     = csa_s;
               c_d     = co_sh;
               cnt_d   = cnt_inc;
               state_d = in_last ? RESOLVE : ACCUM;
            end
         end
         RESOLVE: begin
            if (c_q == '0) begin
               state_d = DONE;
            end else begin
               s_d = csa_s;
               c_d = co_sh;
            end
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) begin
               s_d     = '0;
               c_d     = '0;
               cnt_d   = '0;
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign out_sum   = s_q;
   assign out_count = cnt_q;

endmodule

// File: tb/tb_csa_accum_ctrl.sv
// Randomized and directed checks of csa_accum_ctrl against an arithmetic sum/count model.
module tb_csa_accum_ctrl;

   logic       CLK = 1'b0;
   logic       ASYNCRESETN = 1'b0;
   logic       in_valid = 1'b0;
   logic       in_last = 1'b0;
   logic       out_ready = 1'b0;
   logic [3:0] in_data = 4'h0;

   logic       in_ready, out_valid;
   logic [7:0] out_sum, out_count;
   logic       in_ready2, out_valid2;
   logic [7:0] out_sum2;
   logic [1:0] out_count2;

   int checks = 0;
   int fails = 0;

   logic [3:0] op_q[$];
   int         got_lat;
   logic       ready_ok, timed_out;
   logic [7:0] got_sum, got_cnt, got_sum2;
   logic [1:0] got_cnt2;

   always #5 CLK = ~CLK;

   csa_accum_ctrl #(.WIDTH(4), .ACC_W(8), .CNT_W(8)) dut (
      .CLK(CLK), .ASYNCRESETN(ASYNCRESETN),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
      .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum), .out_count(out_count)
   );

   csa_accum_ctrl #(.WIDTH(4), .ACC_W(8), .CNT_W(2)) dut_sat (
      .CLK(CLK), .ASYNCRESETN(ASYNCRESETN),
      .in_valid(in_valid), .in_ready(in_ready2), .in_data(in_data), .in_last(in_last),
      .out_valid(out_valid2), .out_ready(out_ready), .out_sum(out_sum2), .out_count(out_count2)
   );

   function automatic logic [7:0] model_sum();
      int total = 0;
      foreach (op_q[i]) total += int'(op_q[i]);
      return 8'(total % 256);
   endfunction

   function automatic int model_cnt(input int cap);
      return (op_q.size() > cap) ? cap : op_q.size();
   endfunction

   // Stimulus only: sends op_q, optionally with idle gaps, and captures the result.
   task automatic drive_txn(input int gap_pct, input bit wait_done);
      ready_ok  = 1'b1;
      timed_out = 1'b0;
      got_lat   = 0;
      foreach (op_q[i]) begin
         while (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
            @(negedge CLK);
            in_valid = 1'b0;
            in_last  = 1'($urandom_range(1));
            in_data  = 4'($urandom);
         end
         @(negedge CLK);
         if (!in_ready) ready_ok = 1'b0;
         in_valid = 1'b1;
         in_data  = op_q[i];
         in_last  = (i == op_q.size() - 1);
      end
      @(negedge CLK);
      in_valid = 1'b0;
      in_last  = 1'b0;
      if (wait_done) begin
         while (!out_valid && got_lat < 100) begin
            @(negedge CLK);
            got_lat++;
         end
         if (!out_valid) timed_out = 1'b1;
         got_sum  = out_sum;
         got_cnt  = out_count;
         got_sum2 = out_sum2;
         got_cnt2 = out_count2;
      end
   endtask

   task automatic take_result();
      @(negedge CLK);
      out_ready = 1'b1;
      @(negedge CLK);
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_sum !== 8'h00 || out_count !== 8'h00) begin
         fails++;
         $display("FAIL reset_state: got rdy=%b vld=%b sum=%h cnt=%0d, want rdy=1 vld=0 sum=00 cnt=0",
                  in_ready, out_valid, out_sum, out_count);
      end
      @(negedge CLK);
      ASYNCRESETN = 1'b1;
      @(negedge CLK);
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || in_ready2 !== 1'b1) begin
         fails++;
         $display("FAIL reset_release: got rdy=%b vld=%b rdy2=%b, want 1 0 1", in_ready, out_valid, in_ready2);
      end
   endtask

   task automatic test_single();
      op_q = '{4'h5};
      drive_txn(0, 1'b1);
      checks++;
      if (timed_out || got_sum !== 8'h05 || got_cnt !== 8'd1) begin
         fails++;
         $display("FAIL single_result: got sum=%h cnt=%0d to=%b, want sum=05 cnt=1", got_sum, got_cnt, timed_out);
      end
      checks++;
      if (got_lat != 1) begin
         fails++;
         $display("FAIL single_latency: got %0d cycles after accept edge, want 1", got_lat);
      end
      take_result();
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_sum !== 8'h00 || out_count !== 8'h00) begin
         fails++;
         $display("FAIL single_clear: got rdy=%b vld=%b sum=%h cnt=%0d, want 1 0 00 0",
                  in_ready, out_valid, out_sum, out_count);
      end
   endtask

   task automatic test_back_to_back();
      op_q = '{4'hF, 4'hF, 4'hF};
      drive_txn(0, 1'b1);
      checks++;
      if (timed_out || got_sum !== 8'h2D || got_cnt !== 8'd3) begin
         fails++;
         $display("FAIL b2b_result: got sum=%h cnt=%0d, want sum=2d cnt=3", got_sum, got_cnt);
      end
      checks++;
      if (!ready_ok || got_lat > 9) begin
         fails++;
         $display("FAIL b2b_flow: got ready_ok=%b lat=%0d, want ready_ok=1 lat<=9", ready_ok, got_lat);
      end
      take_result();
   endtask

   task automatic test_wrap();
      op_q.delete();
      repeat (20) op_q.push_back(4'hF);
      drive_txn(0, 1'b1);
      checks++;
      if (timed_out || got_sum !== 8'h2C || got_cnt !== 8'd20) begin
         fails++;
         $display("FAIL wrap_result: got sum=%h cnt=%0d, want sum=2c cnt=20", got_sum, got_cnt);
      end
      checks++;
      if (got_lat > 9) begin
         fails++;
         $display("FAIL wrap_latency: got %0d resolve cycles, want <= 9", got_lat);
      end
      take_result();
   endtask

   task automatic test_backpressure();
      logic bp_ok;
      op_q = '{4'h9, 4'h6};
      drive_txn(0, 1'b1);
      bp_ok = 1'b1;
      for (int i = 0; i < 5; i++) begin
         in_valid = 1'b1;
         in_data  = 4'($urandom);
         in_last  = 1'($urandom_range(1));
         @(negedge CLK);
         if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_sum !== 8'h0F || out_count !== 8'd2)
            bp_ok = 1'b0;
      end
      checks++;
      if (!bp_ok || timed_out) begin
         fails++;
         $display("FAIL backpressure_hold: got vld=%b rdy=%b sum=%h cnt=%0d, want 1 0 0f 2",
                  out_valid, in_ready, out_sum, out_count);
      end
      out_ready = 1'b1;
      @(negedge CLK);
      out_ready = 1'b0;
      in_valid  = 1'b0;
      in_last   = 1'b0;
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_count !== 8'd0) begin
         fails++;
         $display("FAIL backpressure_release: got rdy=%b vld=%b cnt=%0d, want 1 0 0", in_ready, out_valid, out_count);
      end
      op_q = '{4'h3};
      drive_txn(0, 1'b1);
      checks++;
      if (timed_out || got_sum !== 8'h03 || got_cnt !== 8'd1) begin
         fails++;
         $display("FAIL backpressure_next: got sum=%h cnt=%0d, want sum=03 cnt=1", got_sum, got_cnt);
      end
      take_result();
   endtask

   task automatic test_reset_mid_resolve();
      op_q = '{4'hF, 4'hF, 4'hF};
      drive_txn(0, 1'b0);
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
         fails++;
         $display("FAIL resolve_entry: got rdy=%b vld=%b, want 0 0", in_ready, out_valid);
      end
      #2 ASYNCRESETN = 1'b0;
      #1;
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_sum !== 8'h00 || out_count !== 8'h00) begin
         fails++;
         $display("FAIL reset_mid_resolve: got rdy=%b vld=%b sum=%h cnt=%0d, want 1 0 00 0",
                  in_ready, out_valid, out_sum, out_count);
      end
      @(negedge CLK);
      ASYNCRESETN = 1'b1;
      op_q = '{4'h1, 4'h2};
      drive_txn(0, 1'b1);
      checks++;
      if (timed_out || got_sum !== 8'h03 || got_cnt !== 8'd2) begin
         fails++;
         $display("FAIL after_reset_txn: got sum=%h cnt=%0d, want sum=03 cnt=2", got_sum, got_cnt);
      end
      take_result();
   endtask

   task automatic test_saturation();
      op_q = '{4'h1, 4'h1, 4'h1, 4'h1, 4'h1};
      drive_txn(0, 1'b1);
      checks++;
      if (timed_out || got_sum2 !== 8'h05 || got_cnt2 !== 2'd3) begin
         fails++;
         $display("FAIL saturation: got sum=%h cnt=%0d, want sum=05 cnt=3", got_sum2, got_cnt2);
      end
      checks++;
      if (got_cnt !== 8'd5) begin
         fails++;
         $display("FAIL saturation_wide: got cnt=%0d, want 5", got_cnt);
      end
      take_result();
   endtask

   task automatic test_random();
      int n;
      for (int t = 0; t < 40; t++) begin
         op_q.delete();
         n = $urandom_range(1, 30);
         for (int i = 0; i < n; i++) op_q.push_back(4'($urandom));
         drive_txn(30, 1'b1);
         checks++;
         if (timed_out || got_sum !== model_sum() || got_cnt !== 8'(model_cnt(255))
             || got_cnt2 !== 2'(model_cnt(3)) || got_lat > 9) begin
            fails++;
            $display("FAIL random_txn[%0d]: got sum=%h cnt=%0d cnt2=%0d lat=%0d, want sum=%h cnt=%0d cnt2=%0d lat<=9",
                     t, got_sum, got_cnt, got_cnt2, got_lat, model_sum(), model_cnt(255), model_cnt(3));
         end
         take_result();
      end
   endtask

   initial begin
      repeat (2) @(negedge CLK);
      test_reset();
      test_single();
      test_back_to_back();
      test_wrap();
      test_backpressure();
      test_reset_mid_resolve();
      test_saturation();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
